// File: rtl/ntt_mem_checker.sv
// Self-checking memory harness for the NTT memory wrapper: serves LANES-wide reads,
// captures wrapper writes, then compares the captured image with an expected image.
module ntt_mem_checker #(
  parameter int LOGQ   = 64,
  parameter int LOGN   = 12,
  parameter int LANES  = 2,
  parameter int ADDR_W = LOGN - 1,
  parameter int RD_LAT = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_en,
  input  logic                   load_sel,
  input  logic [LOGN-1:0]        load_idx,
  input  logic [LOGQ-1:0]        load_data,
  input  logic                   start,
  output logic                   dut_start,
  input  logic                   dut_finish,
  input  logic [ADDR_W-1:0]      dut_raddr,
  input  logic [ADDR_W-1:0]      dut_waddr,
  input  logic                   dut_wea,
  output logic [LANES*LOGQ-1:0]  dut_din,
  input  logic [LANES*LOGQ-1:0]  dut_dout,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [63:0]            cycle_count,
  output logic [LOGN:0]          err_count,
  output logic [LOGN-1:0]        first_err_idx
);

  localparam int N  = 1 << LOGN;
  localparam int LB = $clog2(LANES);
  localparam int NL = N / LANES;
  localparam int AW = LOGN - LB;
  localparam int W  = LANES * LOGQ;

  localparam logic [LOGN:0]   ERR_SAT  = {1'b1, {LOGN{1'b0}}};
  localparam logic [LOGN:0]   ERR_ONE  = {{LOGN{1'b0}}, 1'b1};
  localparam logic [LOGN-1:0] IDX_ONE  = {{(LOGN-1){1'b0}}, 1'b1};
  localparam logic [LOGN-1:0] IDX_LAST = {LOGN{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic            fin_prev_q;
  logic            dut_start_q, busy_q, done_q, pass_q;
  logic [63:0]     cyc_q, cyc_d;
  logic [LOGN:0]   err_q, err_d;
  logic [LOGN-1:0] first_q, first_d;
  logic [LOGN-1:0] chk_q, chk_d;
  logic [N-1:0]    written_q;
  logic            clr_written_s;
  logic            fin_rise_s;
  logic            chk_fail_s;
  logic            load_ok_s;
  logic            cap_we_s;

  logic [AW-1:0]   ra_s, wa_s, ld_addr_s, chk_addr_s;
  logic [LB-1:0]   ld_lane_s, chk_lane_s;

  // Lane-split storage: lane k at address a holds coefficient index a + k*N/LANES.
  logic [LOGQ-1:0] in_mem_q  [LANES][NL];
  logic [LOGQ-1:0] exp_mem_q [LANES][NL];
  logic [LOGQ-1:0] cap_mem_q [LANES][NL];
  logic [W-1:0]    pipe_q    [RD_LAT];

  assign ra_s       = dut_raddr[AW-1:0];
  assign wa_s       = dut_waddr[AW-1:0];
  assign ld_addr_s  = load_idx[AW-1:0];
  assign ld_lane_s  = load_idx[LOGN-1 -: LB];
  assign chk_addr_s = chk_q[AW-1:0];
  assign chk_lane_s = chk_q[LOGN-1 -: LB];

  if (ADDR_W > AW) begin : g_addr_hi
    logic unused_addr_hi_s;
    assign unused_addr_hi_s = ^{dut_raddr[ADDR_W-1:AW], dut_waddr[ADDR_W-1:AW]};
  end

  assign load_ok_s  = ~rst & ((state_q == S_IDLE) | (state_q == S_DONE));
  assign cap_we_s   = ~rst & dut_wea & (state_q == S_RUN);
  assign fin_rise_s = dut_finish & ~fin_prev_q;
  assign chk_fail_s = ~written_q[chk_q] |
                      (cap_mem_q[chk_lane_s][chk_addr_s] != exp_mem_q[chk_lane_s][chk_addr_s]);

  // Memory contents survive reset so a run can be repeated without reloading.
  always_ff @(posedge clk) begin
    if (load_ok_s && load_en) begin
      if (load_sel) begin
        exp_mem_q[ld_lane_s][ld_addr_s] <= load_data;
      end else begin
        in_mem_q[ld_lane_s][ld_addr_s] <= load_data;
      end
    end
    if (cap_we_s) begin
      for (int k = 0; k < LANES; k++) begin
        cap_mem_q[k][wa_s] <= dut_dout[k*LOGQ +: LOGQ];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < RD_LAT; j++) begin
        pipe_q[j] <= '0;
      end
    end else begin
      for (int k = 0; k < LANES; k++) begin
        pipe_q[0][k*LOGQ +: LOGQ] <= in_mem_q[k][ra_s];
      end
      for (int j = 1; j < RD_LAT; j++) begin
        pipe_q[j] <= pipe_q[j-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr_written_s) begin
      written_q <= '0;
    end else if (cap_we_s) begin
      for (int k = 0; k < LANES; k++) begin
        written_q[LOGN'(k * NL) + LOGN'(wa_s)] <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    cyc_d         = cyc_q;
    err_d         = err_q;
    first_d       = first_q;
    chk_d         = chk_q;
    clr_written_s = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d       = S_RUN;
          cyc_d         = 64'd0;
          err_d         = '0;
          first_d       = '0;
          chk_d         = '0;
          clr_written_s = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      S_RUN: begin
        if (!dut_finish) begin
          cyc_d = cyc_q + 64'd1;
        end else begin
          cyc_d = cyc_q;
        end
        if (fin_rise_s) begin
          state_d = S_CHECK;
          chk_d   = '0;
        end else begin
          state_d = S_RUN;
        end
      end
      S_CHECK: begin
        if (chk_fail_s) begin
          if (err_q != ERR_SAT) begin
            err_d = err_q + ERR_ONE;
          end else begin
            err_d = err_q;
          end
          if (err_q == '0) begin
            first_d = chk_q;
          end else begin
            first_d = first_q;
          end
        end else begin
          err_d = err_q;
        end
        if (chk_q == IDX_LAST) begin
          state_d = S_DONE;
        end else begin
          chk_d = chk_q + IDX_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Status outputs are registered from the next state so they align with state_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      fin_prev_q  <= 1'b0;
      cyc_q       <= 64'd0;
      err_q       <= '0;
      first_q     <= '0;
      chk_q       <= '0;
      dut_start_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      fin_prev_q  <= dut_finish;
      cyc_q       <= cyc_d;
      err_q       <= err_d;
      first_q     <= first_d;
      chk_q       <= chk_d;
      dut_start_q <= (state_d == S_RUN);
      busy_q      <= (state_d == S_RUN) || (state_d == S_CHECK);
      done_q      <= (state_d == S_DONE);
      pass_q      <= (state_d == S_DONE) && (err_d == '0);
    end
  end

  assign dut_start     = dut_start_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign cycle_count   = cyc_q;
  assign err_count     = err_q;
  assign first_err_idx = first_q;
  assign dut_din       = pipe_q[RD_LAT-1];

endmodule

// File: tb/tb_ntt_mem_checker.sv
// Directed bench: two harness instances (N=256/2 lanes/latency 1 and N=64/4 lanes/latency 3)
// driven by a behavioural identity wrapper model.
module tb_ntt_mem_checker;

  localparam int NA = 256, NLA = 128, LATA = 1;
  localparam int NB = 64,  NLB = 16,  LATB = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic         a_load_en, a_load_sel, a_start, a_dut_start, a_finish, a_wea;
  logic [7:0]   a_load_idx, a_first;
  logic [63:0]  a_load_data, a_cyc;
  logic [6:0]   a_raddr, a_waddr;
  logic [127:0] a_din, a_dout;
  logic         a_busy, a_done, a_pass;
  logic [8:0]   a_err;

  logic         b_load_en, b_load_sel, b_start, b_dut_start, b_finish, b_wea;
  logic [5:0]   b_load_idx, b_first;
  logic [63:0]  b_load_data, b_cyc;
  logic [4:0]   b_raddr, b_waddr;
  logic [255:0] b_din, b_dout;
  logic         b_busy, b_done, b_pass;
  logic [6:0]   b_err;

  int n_cmp = 0;
  int n_bad = 0;

  ntt_mem_checker #(.LOGQ(64), .LOGN(8), .LANES(2), .ADDR_W(7), .RD_LAT(1)) u_dut_a (
    .clk(clk), .rst(rst), .load_en(a_load_en), .load_sel(a_load_sel), .load_idx(a_load_idx),
    .load_data(a_load_data), .start(a_start), .dut_start(a_dut_start), .dut_finish(a_finish),
    .dut_raddr(a_raddr), .dut_waddr(a_waddr), .dut_wea(a_wea), .dut_din(a_din), .dut_dout(a_dout),
    .busy(a_busy), .done(a_done), .pass(a_pass), .cycle_count(a_cyc), .err_count(a_err),
    .first_err_idx(a_first));

  ntt_mem_checker #(.LOGQ(64), .LOGN(6), .LANES(4), .ADDR_W(5), .RD_LAT(3)) u_dut_b (
    .clk(clk), .rst(rst), .load_en(b_load_en), .load_sel(b_load_sel), .load_idx(b_load_idx),
    .load_data(b_load_data), .start(b_start), .dut_start(b_dut_start), .dut_finish(b_finish),
    .dut_raddr(b_raddr), .dut_waddr(b_waddr), .dut_wea(b_wea), .dut_din(b_din), .dut_dout(b_dout),
    .busy(b_busy), .done(b_done), .pass(b_pass), .cycle_count(b_cyc), .err_count(b_err),
    .first_err_idx(b_first));

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] coef(input int salt, input int i);
    return 64'(i) * 64'h9E37_79B9_7F4A_7C15 + 64'(salt);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_load(input logic sel, input int idx, input logic [63:0] data);
    a_load_en = 1'b1; a_load_sel = sel; a_load_idx = 8'(idx); a_load_data = data;
    tick();
    a_load_en = 1'b0;
  endtask

  task automatic b_load(input logic sel, input int idx, input logic [63:0] data);
    b_load_en = 1'b1; b_load_sel = sel; b_load_idx = 6'(idx); b_load_data = data;
    tick();
    b_load_en = 1'b0;
  endtask

  // Raise finish and wait for done; optionally pulse start at a given cycle of the wait.
  task automatic a_wait_done(input int start_at, output int lat);
    a_wea = 1'b0;
    a_finish = 1'b1;
    lat = 0;
    while (!a_done && lat < NA + 20) begin
      tick();
      lat++;
      if (lat == 1) check_val("a_start_drop", {62'd0, a_busy, a_dut_start}, 64'd2);
      a_start = (lat == start_at);
    end
    a_start = 1'b0;
    check_val("a_done_seen", 64'(a_done), 64'd1);
    a_finish = 1'b0;
  endtask

  task automatic run_a(input int start_at, input logic poke_load, output int lat);
    int a;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    check_val("a_run_flags", {62'd0, a_busy, a_dut_start}, 64'd3);
    for (int t = 0; t < NLA + LATA; t++) begin
      a_raddr = (t < NLA) ? 7'(t) : 7'd0;
      a_load_en = poke_load && (t == 5);
      a_load_sel = 1'b1; a_load_idx = 8'd3; a_load_data = 64'd0;
      if (t >= LATA) begin
        a = t - LATA;
        a_waddr = 7'(a); a_wea = 1'b1; a_dout = a_din;
        check_val("a_din_l0", a_din[63:0], coef(1, a));
        check_val("a_din_l1", a_din[127:64], coef(1, a + NLA));
      end else begin
        a_wea = 1'b0;
      end
      tick();
    end
    a_load_en = 1'b0;
    a_wait_done(start_at, lat);
  endtask

  task automatic a_results(input string tag, input logic p, input int e, input int f, input int c);
    check_val({tag, "_pass"}, 64'(a_pass), 64'(p));
    check_val({tag, "_err"}, 64'(a_err), 64'(e));
    check_val({tag, "_first"}, 64'(a_first), 64'(f));
    check_val({tag, "_cyc"}, a_cyc, 64'(c));
    check_val({tag, "_flags"}, {62'd0, a_busy, a_done}, 64'd1);
  endtask

  task automatic check_zero_a(input string tag);
    check_val({tag, "_ctl"}, {59'd0, a_dut_start, a_busy, a_done, a_pass, 1'b0}, 64'd0);
    check_val({tag, "_cyc"}, a_cyc, 64'd0);
    check_val({tag, "_err"}, 64'(a_err), 64'd0);
    check_val({tag, "_first"}, 64'(a_first), 64'd0);
  endtask

  int lat;
  int bl;

  initial begin
    rst = 1'b1;
    {a_load_en, a_load_sel, a_start, a_finish, a_wea} = '0;
    a_load_idx = '0; a_load_data = '0; a_raddr = '0; a_waddr = '0; a_dout = '0;
    {b_load_en, b_load_sel, b_start, b_finish, b_wea} = '0;
    b_load_idx = '0; b_load_data = '0; b_raddr = '0; b_waddr = '0; b_dout = '0;
    tick(); tick();
    check_zero_a("rst_a");
    check_val("rst_a_din", {63'd0, |a_din}, 64'd0);
    check_val("rst_b_ctl", {60'd0, b_dut_start, b_busy, b_done, b_pass}, 64'd0);
    check_val("rst_b_din", {63'd0, |b_din}, 64'd0);
    rst = 1'b0;
    tick();

    // Instance A: identity run with expected = input.
    for (int i = 0; i < NA; i++) begin
      a_load(1'b0, i, coef(1, i));
      a_load(1'b1, i, coef(1, i));
    end
    run_a(0, 1'b0, lat);
    check_val("t1_latency", 64'(lat), 64'(NA + 1));
    a_results("t1", 1'b1, 0, 0, NLA + LATA);

    // Corrupt expected[5] and expected[N-1] (loaded while DONE).
    a_load(1'b1, 5, ~coef(1, 5));
    a_load(1'b1, NA - 1, ~coef(1, NA - 1));
    run_a(0, 1'b0, lat);
    a_results("t2", 1'b0, 2, 5, NLA + LATA);
    a_load(1'b1, 5, coef(1, 5));
    a_load(1'b1, NA - 1, coef(1, NA - 1));

    // Finish after exactly 100 RUN cycles with no writes: every index unwritten.
    a_start = 1'b1; tick(); a_start = 1'b0;
    repeat (100) tick();
    a_wait_done(0, lat);
    check_val("t4_latency", 64'(lat), 64'(NA + 1));
    a_results("t4", 1'b0, NA, 0, 100);

    // Reset mid-RUN, then a fresh run with a load attempt during RUN.
    a_start = 1'b1; tick(); a_start = 1'b0;
    a_wea = 1'b1; a_waddr = 7'd3; a_dout = '1;
    repeat (20) tick();
    check_val("t5_cyc_pre", a_cyc, 64'd20);
    rst = 1'b1;
    tick();
    check_zero_a("t5_rst1");
    check_val("t5_rst_din", {63'd0, |a_din}, 64'd0);
    tick();
    check_zero_a("t5_rst2");
    rst = 1'b0; a_wea = 1'b0;
    tick();
    check_zero_a("t5_after");
    run_a(0, 1'b1, lat);
    a_results("t5", 1'b1, 0, 0, NLA + LATA);

    // start during CHECK and writes during DONE are ignored.
    run_a(10, 1'b0, lat);
    check_val("t6_latency", 64'(lat), 64'(NA + 1));
    a_results("t6", 1'b1, 0, 0, NLA + LATA);
    a_wea = 1'b1; a_waddr = 7'd0; a_dout = '1;
    repeat (5) tick();
    a_wea = 1'b0;
    a_results("t6_done", 1'b1, 0, 0, NLA + LATA);

    // Instance B: 4 lanes, latency 3, address upper bit set, write address 7 skipped.
    for (int i = 0; i < NB; i++) begin
      b_load(1'b0, i, coef(2, i));
      b_load(1'b1, i, coef(2, i));
    end
    b_start = 1'b1; tick(); b_start = 1'b0;
    for (int t = 0; t < NLB + LATB; t++) begin
      b_raddr = (t < NLB) ? (5'(t) | 5'd16) : 5'd16;
      if (t >= LATB) begin
        b_waddr = 5'(t - LATB) | 5'd16;
        b_wea = ((t - LATB) != 7);
        b_dout = b_din;
        for (int k = 0; k < 4; k++) begin
          check_val("b_din_lane", b_din[k*64 +: 64], coef(2, (t - LATB) + k * NLB));
        end
      end else begin
        b_wea = 1'b0;
      end
      tick();
    end
    b_wea = 1'b0; b_finish = 1'b1; bl = 0;
    while (!b_done && bl < NB + 20) begin
      tick();
      bl++;
    end
    b_finish = 1'b0;
    check_val("b_latency", 64'(bl), 64'(NB + 1));
    check_val("b_err", 64'(b_err), 64'd4);
    check_val("b_first", 64'(b_first), 64'd7);
    check_val("b_pass", 64'(b_pass), 64'd0);
    check_val("b_cyc", b_cyc, 64'(NLB + LATB));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/ntt_mem_checker.md
# ntt_mem_checker

Synthesizable, parametrised self-checking memory harness for the NTT memory wrapper. It replaces the fixed two-lane behavioural memory models with a LANES-wide coefficient source and capture memory. It drives the wrapper's start, serves its read addresses with configurable latency, and captures its writes. On finish it compares every captured coefficient against a preloaded expected image and reports cycle count, error count and first failing index. It sits beside one wrapper instance, forward or inverse, in simulation and in on-FPGA bring-up.

## Interface
- LOGQ, 64: coefficient width.
- LOGN, 12: log2 of the transform length; N = 2^LOGN.
- LANES, 2: coefficients per address; power of 2, 2..16.
- ADDR_W, LOGN-1: wrapper address width; must be ≥ log2(N/LANES).
- RD_LAT, 1: read latency in cycles from address to data; 1..4.

- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- load_en  in  1  preload write strobe; honoured only in IDLE/DONE.
- load_sel  in  1  0 = input image, 1 = expected image.
- load_idx  in  LOGN  coefficient index 0..N-1.
- load_data  in  LOGQ  coefficient value.
- start  in  1  begin a run; pulse or level.
- dut_start  out  1  start to the wrapper.
- dut_finish  in  1  finish from the wrapper.
- dut_raddr  in  ADDR_W  wrapper read address.
- dut_waddr  in  ADDR_W  wrapper write address.
- dut_wea  in  1  wrapper write enable.
- dut_din  out  LANES*LOGQ  lane k in bits [k*LOGQ +: LOGQ] = input[raddr + k*N/LANES].
- dut_dout  in  LANES*LOGQ  lane k written to capture[waddr + k*N/LANES].
- busy  out  1  high in RUN or CHECK.
- done  out  1  high in DONE.
- pass  out  1  valid when done; 1 iff err_count == 0.
- cycle_count  out  64  cycles spent in RUN with dut_finish low.
- err_count  out  LOGN+1  mismatching or unwritten indices; saturates at N.
- first_err_idx  out  LOGN  lowest failing index; 0 if none.

## Operation
- FSM states: IDLE → RUN → CHECK → DONE. DONE goes back to RUN on start.
- IDLE: load_en writes input[load_idx] or expected[load_idx]. On start, go to RUN; cycle_count, err_count, first_err_idx and the N-bit written vector are cleared.
- RUN:
  - dut_start = 1.
  - Read: dut_raddr is sampled every cycle. All LANES words appear on dut_din exactly RD_LAT cycles later through an RD_LAT-deep pipeline. Reads are also served in IDLE/DONE, with output value don't-care.
  - Write: when dut_wea = 1, all LANES words are written at the sampling edge, and written[idx] is set for each lane.
  - Rising edge of dut_finish (registered previous value 0, current 1): deassert dut_start next cycle and go to CHECK.
- CHECK: one index per cycle, i = 0..N-1, so N cycles. An index fails if written[i] == 0 or capture[i] != expected[i]. The first failure latches first_err_idx. err_count increments per failure, saturating at N. After i = N-1, go to DONE.
- DONE: done = 1; pass = (err_count == 0). Results hold until the next start.
- Address arithmetic is modulo N/LANES on the low log2(N/LANES) bits. Upper bits of dut_raddr/dut_waddr are ignored, with no wrap into another lane.
- The sum idx = addr + k*N/LANES never overflows LOGN bits.

## Timing
- Reset values: dut_start 0, busy 0, done 0, pass 0, cycle_count 0, err_count 0, first_err_idx 0, dut_din 0, state IDLE. Memory contents are not cleared by reset.
- Reset in any state forces IDLE next cycle and zeroes all outputs. An in-flight read pipeline is flushed to 0.
- start while in RUN or CHECK is ignored. load_en while in RUN or CHECK is ignored.
- dut_wea and the dut_finish rising edge in the same cycle: the write is captured.
- dut_wea in CHECK or DONE is ignored.
- cycle_count increments on each RUN cycle with dut_finish = 0. It excludes the finish cycle and wraps at 2^64.
- Two writes to the same index in one run: the last write wins; this is not an error.
- dut_finish already high on RUN entry: no rising edge occurs, so the block stays in RUN until finish drops and rises again.
- Latency from the finish edge to done = N + 1 cycles.

## Test plan
- LANES=2, RD_LAT=1, identity DUT model that writes each read back, expected = input: pass = 1, err_count = 0, and dut_din lane 1 = input[raddr + N/2] one cycle after each address.
- Same setup, with expected[5] and expected[N-1] corrupted: err_count = 2, first_err_idx = 5, pass = 0.
- LANES=4, RD_LAT=3, N=64, model skips write address 7: indices 7, 23, 39, 55 fail; err_count = 4; first_err_idx = 7.
- Finish asserted after exactly 100 RUN cycles: cycle_count = 100; done rises N + 1 cycles after the finish edge.
- Reset pulsed mid-RUN, then a fresh start: outputs are 0 during and after reset, and the second run reports correct results without reloading memories.
- start pulsed during CHECK and dut_wea asserted during DONE: both ignored, and results are unchanged.
